// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: grid geometry, cell encodings and
// the arbiter FSM state encoding.
package snake_pkg;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int CELL_PX = 20;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BODY  = 2'd1;
    localparam logic [1:0] CELL_HEAD  = 2'd2;
    localparam logic [1:0] CELL_FOOD  = 2'd3;

    // One access is issued from IDLE; the following state consumes its result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_GAME = 2'd2,
        ST_CLR  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/grid_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
// Kept behavioural so it can be swapped for a block-RAM primitive.
module grid_ram #(
    parameter int DEPTH  = 768,
    parameter int DATA_W = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One access per enabled cycle; the old contents appear on rdata next cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/grid_mem_arbiter.sv
// Owns the playfield cell RAM and shares its single port between the VGA
// renderer (hard priority), the full-grid clear sequencer and the game FSM.
module grid_mem_arbiter #(
    parameter int GRID_W  = snake_pkg::GRID_W,
    parameter int GRID_H  = snake_pkg::GRID_H,
    parameter int CELL_PX = snake_pkg::CELL_PX,
    parameter int ADDR_W  = 10,
    parameter int CELL_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_hcount,
    input  logic [9:0]        i_vcount,
    input  logic              i_video_on,
    output logic [CELL_W-1:0] o_cell_type,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CELL_W-1:0] i_wdata,
    output logic              o_ack,
    output logic [CELL_W-1:0] o_rdata,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_clear_done
);

    import snake_pkg::*;

    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_CELLS - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic [ADDR_W-1:0] r_last_addr;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_busy;
    logic              r_acc_ok;
    logic              r_game_we;
    logic [CELL_W-1:0] r_cell_type;
    logic [CELL_W-1:0] r_rdata;

    logic [9:0]        w_col;
    logic [9:0]        w_row;
    logic [19:0]       w_vaddr_full;
    logic [ADDR_W-1:0] w_vaddr;
    logic              w_vid_ok;
    logic              w_vid_need;
    logic              w_game_ok;
    logic              w_clr_last;
    logic              w_take_vid;
    logic              w_take_game;
    logic [CELL_W-1:0] w_ram_out;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CELL_W-1:0] ram_wdata;
    logic [CELL_W-1:0] ram_rdata;

    // Pixel to cell: constant divide, then row-major address. Computed wide so
    // off-grid pixels are detected instead of aliasing onto real cells.
    assign w_col        = i_hcount / 10'(CELL_PX);
    assign w_row        = i_vcount / 10'(CELL_PX);
    assign w_vaddr_full = 20'(w_row) * 20'(GRID_W) + 20'(w_col);
    assign w_vaddr      = w_vaddr_full[ADDR_W-1:0];
    assign w_vid_ok     = (w_vaddr_full < 20'(GRID_CELLS));
    assign w_vid_need   = i_video_on && (w_vaddr != r_last_addr);

    assign w_game_ok    = (i_addr < ADDR_W'(GRID_CELLS));
    assign w_clr_last   = (r_clr_addr == LAST_ADDR);
    assign w_ram_out    = r_acc_ok ? ram_rdata : CELL_W'(CELL_EMPTY);

    assign o_ack        = (r_state == ST_GAME);
    assign o_clear_done = (r_state == ST_CLR) && w_clr_last;
    assign o_busy       = r_busy;
    assign o_cell_type  = r_cell_type;
    assign o_rdata      = (o_ack && !r_game_we) ? w_ram_out : r_rdata;

    grid_ram #(
        .DEPTH  (GRID_CELLS),
        .DATA_W (CELL_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (i_clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Slot arbitration from IDLE (video > clear > game) and RAM port drive.
    always_comb begin
        w_next_state = r_state;
        w_take_vid   = 1'b0;
        w_take_game  = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_vid_need) begin
                    w_next_state = ST_VID;
                    w_take_vid   = 1'b1;
                    ram_en       = 1'b1;
                    ram_addr     = w_vid_ok ? w_vaddr : '0;
                end else if (r_busy || i_clear) begin
                    w_next_state = ST_CLR;
                    ram_en       = 1'b1;
                    ram_we       = 1'b1;
                    ram_addr     = r_clr_addr;
                    ram_wdata    = CELL_W'(CELL_EMPTY);
                end else if (i_req) begin
                    w_next_state = ST_GAME;
                    w_take_game  = 1'b1;
                    ram_en       = 1'b1;
                    ram_we       = i_we && w_game_ok;
                    ram_addr     = w_game_ok ? i_addr : '0;
                    ram_wdata    = i_wdata;
                end
            end
            ST_VID:  w_next_state = ST_IDLE;
            ST_GAME: w_next_state = ST_IDLE;
            ST_CLR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bookkeeping: last fetched video cell, clear progress and captured data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_addr <= '1;
            r_clr_addr  <= '0;
            r_busy      <= 1'b0;
            r_acc_ok    <= 1'b0;
            r_game_we   <= 1'b0;
            r_cell_type <= '0;
            r_rdata     <= '0;
        end else begin
            if (!i_video_on) begin
                r_last_addr <= '1;
            end else if (w_take_vid) begin
                r_last_addr <= w_vaddr;
            end

            if (w_take_vid) begin
                r_acc_ok <= w_vid_ok;
            end else if (w_take_game) begin
                r_acc_ok  <= w_game_ok;
                r_game_we <= i_we;
            end

            if (o_clear_done) begin
                r_busy <= 1'b0;
            end else if (i_clear) begin
                r_busy <= 1'b1;
            end

            if (r_state == ST_CLR) begin
                r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
            end

            if (r_state == ST_VID) begin
                r_cell_type <= w_ram_out;
            end

            if (o_ack && !r_game_we) begin
                r_rdata <= w_ram_out;
            end
        end
    end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter: game accesses push expected responses
// into a queue that a separate monitor pops on every o_ack.
module tb_grid_mem_arbiter;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [9:0] i_hcount = '0;
    logic [9:0] i_vcount = '0;
    logic       i_video_on = 1'b0;
    logic [1:0] o_cell_type;
    logic       i_req = 1'b0;
    logic       i_we = 1'b0;
    logic [9:0] i_addr = '0;
    logic [1:0] i_wdata = '0;
    logic       o_ack;
    logic [1:0] o_rdata;
    logic       i_clear = 1'b0;
    logic       o_busy;
    logic       o_clear_done;

    typedef struct packed {
        logic       is_read;
        logic [1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_count = 0;

    grid_mem_arbiter dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_hcount     (i_hcount),
        .i_vcount     (i_vcount),
        .i_video_on   (i_video_on),
        .o_cell_type  (o_cell_type),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ack        (o_ack),
        .o_rdata      (o_rdata),
        .i_clear      (i_clear),
        .o_busy       (o_busy),
        .o_clear_done (o_clear_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Scoreboard monitor: every ack consumes one expected response.
    always @(negedge clk) begin
        if (!i_rst && o_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("[TB] FAIL unexpected_ack: o_ack=1 with no access outstanding");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_read && o_rdata !== e.data) begin
                    n_errors++;
                    $display("[TB] FAIL ack_rdata: got %0d expected %0d", o_rdata, e.data);
                end
            end
        end
    end

    // Counts clear-done pulses for the directed checks.
    always @(negedge clk) begin
        if (!i_rst && o_clear_done) done_count++;
    end

    task automatic check_output(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Issue one game access at a negedge, hold i_req until ack or budget expiry.
    task automatic apply_game(input logic we, input logic [9:0] addr, input logic [1:0] wdata,
                              input logic [1:0] exp_rd, input int budget, input string name);
        bit got = 0;
        @(negedge clk);
        exp_q.push_back('{is_read: !we, data: exp_rd});
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (o_ack) begin
                got = 1;
                break;
            end
        end
        i_req = 1'b0; i_we = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("[TB] FAIL %s: no o_ack within %0d cycles", name, budget);
        end
    endtask

    // Move the pixel and require o_cell_type to show exp within 3 cycles.
    task automatic apply_pixel(input logic [9:0] hc, input logic [9:0] vc,
                               input logic [1:0] exp_cell, input string name);
        bit got = 0;
        @(negedge clk);
        i_hcount = hc; i_vcount = vc; i_video_on = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (o_cell_type === exp_cell) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("[TB] FAIL %s: o_cell_type=%0d expected %0d within 3 cycles",
                     name, o_cell_type, exp_cell);
        end
    endtask

    initial begin
        int done_c;
        int ack_c;
        int done_before;

        // 1: reset state, then HEAD at cell 0 seen by the renderer.
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        check_output("rst_cell_type", int'(o_cell_type), 0);
        check_output("rst_ack", int'(o_ack), 0);
        check_output("rst_rdata", int'(o_rdata), 0);
        check_output("rst_busy", int'(o_busy), 0);
        check_output("rst_clear_done", int'(o_clear_done), 0);
        apply_game(1'b1, 10'd0, 2'd2, 2'd0, 4, "wr0_head");
        apply_pixel(10'd0, 10'd0, 2'd2, "pix_0_0_head");

        // 2: FOOD at cell 33 via write/read, then pixel (25,25) lands on it.
        apply_game(1'b1, 10'd33, 2'd3, 2'd0, 4, "wr33_food");
        apply_game(1'b0, 10'd33, 2'd0, 2'd3, 4, "rd33_food");
        apply_pixel(10'd25, 10'd25, 2'd3, "pix_25_25_food");
        apply_game(1'b1, 10'd1, 2'd1, 2'd0, 4, "wr1_body");

        // 3: column change 0->1 while a game read is pending: video preempts.
        apply_pixel(10'd19, 10'd0, 2'd2, "pix_19_0_head");
        fork
            apply_game(1'b0, 10'd33, 2'd0, 2'd3, 3, "rd33_preempted");
            apply_pixel(10'd20, 10'd0, 2'd1, "pix_20_0_body");
        join

        // 4: fill with BODY, then clear with a competing request.
        @(negedge clk);
        i_video_on = 1'b0;
        for (int a = 0; a < 768; a++) begin
            apply_game(1'b1, 10'(a), 2'd1, 2'd0, 4, "fill_body");
        end
        apply_game(1'b0, 10'd500, 2'd0, 2'd1, 4, "rd500_body");
        done_before = done_count;
        @(negedge clk);
        exp_q.push_back('{is_read: 1'b1, data: 2'd0});
        i_clear = 1'b1; i_req = 1'b1; i_we = 1'b0; i_addr = 10'd5;
        done_c = 0; ack_c = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                i_clear = 1'b0;
                check_output("clr_busy_high", int'(o_busy), 1);
            end
            if (c == 100) i_clear = 1'b1;
            if (c == 101) i_clear = 1'b0;
            if (o_clear_done && done_c == 0) done_c = c;
            if (o_ack) begin
                ack_c = c;
                break;
            end
        end
        i_req = 1'b0;
        check_output("clr_done_cycle", done_c, 1535);
        check_output("clr_ack_cycle", ack_c, 1537);
        check_output("clr_done_pulses", done_count - done_before, 1);
        check_output("clr_busy_low", int'(o_busy), 0);
        apply_game(1'b0, 10'd0, 2'd0, 2'd0, 4, "rd0_cleared");
        apply_game(1'b0, 10'd767, 2'd0, 2'd0, 4, "rd767_cleared");
        apply_game(1'b0, 10'd400, 2'd0, 2'd0, 4, "rd400_cleared");

        // 5: out-of-range address: acked, never written, reads as 0.
        apply_game(1'b1, 10'd800, 2'd3, 2'd0, 4, "wr800_oob");
        apply_game(1'b0, 10'd800, 2'd0, 2'd0, 4, "rd800_oob");
        apply_game(1'b0, 10'd32, 2'd0, 2'd0, 4, "rd32_untouched");
        apply_game(1'b0, 10'd288, 2'd0, 2'd0, 4, "rd288_untouched");

        // 6: reset in the middle of a clear.
        apply_game(1'b1, 10'd700, 2'd2, 2'd0, 4, "wr700_head");
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        repeat (48) @(negedge clk);
        check_output("midclr_busy", int'(o_busy), 1);
        done_before = done_count;
        i_rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_busy", int'(o_busy), 0);
        check_output("rst_mid_ack", int'(o_ack), 0);
        check_output("rst_mid_done", int'(o_clear_done), 0);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);
        check_output("rst_mid_no_done", done_count - done_before, 0);
        apply_game(1'b0, 10'd700, 2'd0, 2'd2, 2, "rd700_kept");
        apply_game(1'b0, 10'd0, 2'd0, 2'd0, 2, "rd0_after_rst");

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL pending_acks: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
